// File: rtl/sram_axi_if.sv
// AXI4 channel bundle between a bus master and the SRAM slave.
// Signal names follow the AXI specification so waveforms read naturally.
interface sram_axi_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/sram_axi_slave.sv
// AXI4 slave fronting a single-port synchronous SRAM, one transaction (read or write) in flight.
// Latency: AR accept -> RVALID 2 cycles, 2 cycles per read beat; 1 cycle per write beat; B the cycle after WLAST.
// Backpressure: RDATA held while RREADY low; SRAM only touched on a W handshake or RD_REQ; AR/AW refused outside IDLE.
module sram_axi_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic                clk,
    input  logic                rst,
    sram_axi_if.slave           axi,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [DATA_W/8-1:0] sram_bwe,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);
    localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [1:0]          burst_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                err_q;
    logic                rd_first_q;
    logic [DATA_W-1:0]   rdata_q;

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs, rd_last;
    logic [MEM_AW-1:0] addr_nxt;

    assign aw_hs    = axi.AWVALID && axi.AWREADY;
    assign ar_hs    = axi.ARVALID && axi.ARREADY;
    assign w_hs     = axi.WVALID  && axi.WREADY;
    assign r_hs     = axi.RVALID  && axi.RREADY;
    assign b_hs     = axi.BVALID  && axi.BREADY;
    assign rd_last  = (cnt_q == len_q);
    // FIXED holds the address; INCR and the reserved encoding both step by one word.
    assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_ONE;

    // Word-only access: size and sub-word/upper address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{axi.AWSIZE, axi.ARSIZE,
                           axi.AWADDR[ADDR_W-1:MEM_AW+2], axi.AWADDR[1:0],
                           axi.ARADDR[ADDR_W-1:MEM_AW+2], axi.ARADDR[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aw_hs) state_d = WR_DATA;
                     else if (ar_hs) state_d = RD_REQ;
            RD_REQ:  state_d = RD_DATA;
            RD_DATA: if (r_hs) state_d = rd_last ? IDLE : RD_REQ;
            WR_DATA: if (w_hs && axi.WLAST) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi.AWREADY = 1'b0;
        axi.ARREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BID     = '0;
        axi.BRESP   = 2'b00;
        axi.RVALID  = 1'b0;
        axi.RID     = '0;
        axi.RDATA   = '0;
        axi.RRESP   = 2'b00;
        axi.RLAST   = 1'b0;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_bwe    = '0;
        sram_addr   = '0;
        sram_wdata  = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst so every output reads 0 during reset.
                axi.AWREADY = !rst;
                axi.ARREADY = !rst && !axi.AWVALID;
            end
            RD_REQ: begin
                sram_cs   = 1'b1;
                sram_addr = addr_q;
            end
            RD_DATA: begin
                axi.RVALID = 1'b1;
                axi.RID    = id_q;
                // First cycle forwards the macro output, later stall cycles replay the captured copy.
                axi.RDATA  = rd_first_q ? sram_rdata : rdata_q;
                axi.RLAST  = rd_last;
            end
            WR_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_bwe   = axi.WSTRB;
                    sram_addr  = addr_q;
                    sram_wdata = axi.WDATA;
                end
            end
            WR_RESP: begin
                axi.BVALID = 1'b1;
                axi.BID    = id_q;
                axi.BRESP  = err_q ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= 2'b00;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_first_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_first_q <= (state_q == RD_REQ);
            if (rd_first_q) rdata_q <= sram_rdata;
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q    <= axi.AWID;
                        addr_q  <= axi.AWADDR[MEM_AW+1:2];
                        len_q   <= axi.AWLEN;
                        burst_q <= axi.AWBURST;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end else if (ar_hs) begin
                        id_q    <= axi.ARID;
                        addr_q  <= axi.ARADDR[MEM_AW+1:2];
                        len_q   <= axi.ARLEN;
                        burst_q <= axi.ARBURST;
                        cnt_q   <= '0;
                    end
                end
                RD_DATA: begin
                    if (r_hs && !rd_last) begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        addr_q <= addr_nxt;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        cnt_q  <= cnt_q + CNT_ONE;
                        addr_q <= addr_nxt;
                        // A WLAST that disagrees with AWLEN is answered with SLVERR.
                        if (axi.WLAST) err_q <= (cnt_q != len_q);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_slave.sv
// Bench for sram_axi_slave: vector table of AXI transactions plus hand sequences, with a
// behavioural SRAM and a reference memory feeding write/read scoreboards.
module tb_sram_axi_slave;
    logic        clk;
    logic        rst;
    logic        sram_cs, sram_we;
    logic [3:0]  sram_bwe;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    sram_axi_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) axi ();

    sram_axi_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MEM_AW(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .axi        (axi),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_bwe   (sram_bwe),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macro: read data appears the cycle after the read access.
    logic [31:0] mem [0:16383];
    int acc_cnt = 0;
    always @(posedge clk) begin
        if (sram_cs) begin
            acc_cnt <= acc_cnt + 1;
            if (sram_we) begin
                for (int k = 0; k < 4; k++)
                    if (sram_bwe[k]) mem[sram_addr][k*8 +: 8] <= sram_wdata[k*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        bit          wr;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          nbeats;
        logic [3:0]  strb;
        logic [31:0] dbase;
        bit          tog;
        logic [1:0]  resp;
    } vec_t;

    typedef struct { logic [13:0] addr; logic [31:0] data; logic [3:0] strb; } wr_exp_t;
    typedef struct { logic [13:0] addr; logic [31:0] data; bit last; } rd_exp_t;

    logic [31:0] ref_mem [0:16383];
    wr_exp_t wq[$];
    rd_exp_t rq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  ar_pending = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic vec_t mk(bit wr, logic [7:0] id, logic [31:0] addr, logic [3:0] len,
                                logic [1:0] burst, int nbeats, logic [3:0] strb,
                                logic [31:0] dbase, bit tog, logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst;
        v.nbeats = nbeats; v.strb = strb; v.dbase = dbase; v.tog = tog; v.resp = resp;
        return v;
    endfunction

    function automatic logic [13:0] waddr(logic [31:0] a, logic [1:0] b, int i);
        logic [13:0] w;
        w = a[15:2];
        if (b != 2'b00) w = w + 14'(i);
        return w;
    endfunction

    task automatic do_write(input vec_t v);
        int base;
        bit ok;
        wr_exp_t e;
        base = acc_cnt;
        for (int i = 0; i < v.nbeats; i++) begin
            e.addr = waddr(v.addr, v.burst, i);
            e.data = v.dbase + 32'(i) * 32'h0101_0101;
            e.strb = v.strb;
            wq.push_back(e);
            for (int k = 0; k < 4; k++)
                if (e.strb[k]) ref_mem[e.addr][k*8 +: 8] = e.data[k*8 +: 8];
        end
        axi.AWID = v.id; axi.AWADDR = v.addr; axi.AWLEN = v.len;
        axi.AWSIZE = 3'd2; axi.AWBURST = v.burst; axi.AWVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (axi.AWREADY) begin
                ok = 1'b1;
                if (ar_pending) chk("ar_loses_to_aw", 64'(axi.ARREADY), 64'(0));
            end
            @(posedge clk); #1;
        end
        if (!ok) timeout("aw_accept");
        axi.AWVALID = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            axi.WDATA = wq[0].data; axi.WSTRB = wq[0].strb;
            axi.WLAST = (b == v.nbeats - 1); axi.WVALID = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 20 && !ok; c++) begin
                #1;
                if (axi.WREADY) begin
                    ok = 1'b1;
                    chk("w_cs_we", 64'({sram_cs, sram_we}), 64'(2'b11));
                    chk("w_addr", 64'(sram_addr), 64'(wq[0].addr));
                    chk("w_bwe", 64'(sram_bwe), 64'(wq[0].strb));
                    chk("w_wdata", 64'(sram_wdata), 64'(wq[0].data));
                    void'(wq.pop_front());
                end
                @(posedge clk); #1;
            end
            if (!ok) timeout("w_accept");
        end
        axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (c == 0) chk("b_after_wlast", 64'(axi.BVALID), 64'(1));
            if (axi.BVALID) begin
                ok = 1'b1;
                chk("bid", 64'(axi.BID), 64'(v.id));
                chk("bresp", 64'(axi.BRESP), 64'(v.resp));
                if (ar_pending) chk("ar_blocked_in_b", 64'(axi.ARREADY), 64'(0));
            end
            @(posedge clk); #1;
        end
        if (!ok) timeout("b_resp");
        axi.BREADY = 1'b0;
        chk("w_access_count", 64'(acc_cnt - base), 64'(v.nbeats));
    endtask

    task automatic do_read(input vec_t v);
        int base, nb, lat;
        bit ok, ph, done, first;
        rd_exp_t e;
        nb = int'(v.len) + 1;
        for (int i = 0; i < nb; i++) begin
            e.addr = waddr(v.addr, v.burst, i);
            e.data = ref_mem[e.addr];
            e.last = (i == nb - 1);
            rq.push_back(e);
        end
        base = acc_cnt;
        axi.ARID = v.id; axi.ARADDR = v.addr; axi.ARLEN = v.len;
        axi.ARSIZE = 3'd2; axi.ARBURST = v.burst; axi.ARVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (ar_pending && c == 0) chk("ar_after_b", 64'(axi.ARREADY), 64'(1));
            if (axi.ARREADY) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) timeout("ar_accept");
        axi.ARVALID = 1'b0;
        ar_pending = 1'b0;
        lat = 1; ph = 1'b0; done = 1'b0; first = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            axi.RREADY = v.tog ? ph : 1'b1;
            #1;
            if (sram_cs) begin
                chk("r_we_low", 64'(sram_we), 64'(0));
                if (rq.size() > 0) chk("r_sram_addr", 64'(sram_addr), 64'(rq[0].addr));
            end
            if (axi.RVALID) begin
                if (rq.size() == 0) begin
                    timeout("r_unexpected_beat");
                    done = 1'b1;
                end else begin
                    if (first) begin
                        chk("r_first_latency", 64'(lat), 64'(2));
                        first = 1'b0;
                    end
                    chk("rdata", 64'(axi.RDATA), 64'(rq[0].data));
                    chk("rid", 64'(axi.RID), 64'(v.id));
                    if (axi.RREADY) begin
                        chk("rlast", 64'(axi.RLAST), 64'(rq[0].last));
                        chk("rresp", 64'(axi.RRESP), 64'(0));
                        if (rq[0].last) done = 1'b1;
                        void'(rq.pop_front());
                    end
                end
                ph = ~ph;
            end
            lat++;
            @(posedge clk); #1;
        end
        axi.RREADY = 1'b0;
        if (!done) timeout("r_beats");
        chk("r_access_count", 64'(acc_cnt - base), 64'(nb));
    endtask

    vec_t vec [13];
    int   base;
    bit   ok;

    initial begin
        rst = 1'b1;
        axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
        axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0;
        axi.RREADY = 1'b0;

        //          wr   id     addr          len   burst  beats strb     dbase         tog  resp
        vec[0]  = mk(1, 8'h5A, 32'h1000_0010, 4'd0, 2'b01, 1, 4'hF,    32'hDEAD_BEEF, 0, 2'b00);
        vec[1]  = mk(0, 8'h21, 32'h0000_0010, 4'd0, 2'b01, 1, 4'h0,    32'h0,         0, 2'b00);
        vec[2]  = mk(1, 8'h33, 32'h0000_0010, 4'd0, 2'b01, 1, 4'b0100, 32'h1122_3344, 0, 2'b00);
        vec[3]  = mk(0, 8'h34, 32'h0000_0010, 4'd0, 2'b01, 1, 4'h0,    32'h0,         0, 2'b00);
        vec[4]  = mk(1, 8'h40, 32'h0000_0014, 4'd2, 2'b01, 3, 4'hF,    32'hA0A0_0001, 0, 2'b00);
        vec[5]  = mk(0, 8'h41, 32'h0000_0010, 4'd3, 2'b01, 4, 4'h0,    32'h0,         1, 2'b00);
        vec[6]  = mk(1, 8'h50, 32'h0000_FFFC, 4'd1, 2'b01, 2, 4'hF,    32'h1234_5678, 0, 2'b00);
        vec[7]  = mk(0, 8'h51, 32'h0000_FFFC, 4'd1, 2'b01, 2, 4'h0,    32'h0,         0, 2'b00);
        vec[8]  = mk(1, 8'h60, 32'h0000_0100, 4'd1, 2'b01, 1, 4'hF,    32'hCAFE_0000, 0, 2'b10);
        vec[9]  = mk(1, 8'h70, 32'h0000_0040, 4'd2, 2'b00, 3, 4'hF,    32'h0000_0001, 0, 2'b00);
        vec[10] = mk(0, 8'h71, 32'h0000_0040, 4'd2, 2'b00, 3, 4'h0,    32'h0,         1, 2'b00);
        vec[11] = mk(0, 8'h72, 32'h0000_0014, 4'd1, 2'b11, 2, 4'h0,    32'h0,         0, 2'b00);
        vec[12] = mk(0, 8'h73, 32'h0000_0100, 4'd0, 2'b01, 1, 4'h0,    32'h0,         0, 2'b00);

        repeat (2) @(posedge clk);
        #2;
        chk("rst_axi_ctrl", 64'({axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST}), 64'(0));
        chk("rst_sram_ctrl", 64'({sram_cs, sram_we, sram_bwe}), 64'(0));
        chk("rst_rdata", 64'(axi.RDATA), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'({axi.AWREADY, axi.ARREADY}), 64'(2'b11));
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            if (vec[i].wr) do_write(vec[i]);
            else           do_read(vec[i]);
        end

        // AW and AR raised together: write wins, read goes after the B handshake.
        axi.ARID = 8'h91; axi.ARADDR = 32'h0000_0018; axi.ARLEN = 4'd0;
        axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
        ar_pending = 1'b1;
        do_write(mk(1, 8'h90, 32'h0000_0200, 4'd0, 2'b01, 1, 4'hF, 32'h0BAD_F00D, 0, 2'b00));
        do_read(mk(0, 8'h91, 32'h0000_0018, 4'd0, 2'b01, 1, 4'h0, 32'h0, 0, 2'b00));

        // Reset asserted in RD_DATA of an 8-beat burst.
        axi.ARID = 8'h77; axi.ARADDR = 32'h0000_0010; axi.ARLEN = 4'd7;
        axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (axi.ARREADY) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) timeout("rst_ar_accept");
        axi.ARVALID = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (axi.RVALID) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) timeout("rst_rvalid");
        rst = 1'b1;
        #1;
        chk("midrst_axi_ctrl", 64'({axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST}), 64'(0));
        chk("midrst_rid_rdata", 64'({axi.RID, axi.RDATA}), 64'(0));
        chk("midrst_sram", 64'({sram_cs, sram_we, sram_addr}), 64'(0));
        base = acc_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_access", 64'(acc_cnt - base), 64'(0));
        do_read(mk(0, 8'h78, 32'h0000_0010, 4'd0, 2'b01, 1, 4'h0, 32'h0, 0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
